// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI lane striper.
//   dsi_state_t  : striper FSM states
//   STRB_*       : the only strobe patterns a packet word may carry
//   dsi_word_t   : one word offered by the packet interface
//   strb_legal() : strobe is one of the contiguous low-byte masks
//   strb_bytes() : bytes appended for a strobe (illegal masks count as 4)
package dsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE,
        ST_ERROR
    } dsi_state_t;

    localparam logic [3:0] STRB_B1 = 4'h1;
    localparam logic [3:0] STRB_B2 = 4'h3;
    localparam logic [3:0] STRB_B3 = 4'h7;
    localparam logic [3:0] STRB_B4 = 4'hf;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } dsi_word_t;

    function automatic logic strb_legal(input logic [3:0] s);
        return s inside {STRB_B1, STRB_B2, STRB_B3, STRB_B4};
    endfunction

    function automatic logic [2:0] strb_bytes(input logic [3:0] s);
        case (s)
            STRB_B1: return 3'd1;
            STRB_B2: return 3'd2;
            STRB_B3: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dsi_byte_fifo.sv
// Byte-granular circular buffer: up to 4 bytes pushed and up to MAX_POP
// bytes popped per cycle, both allowed in the same cycle.
//   clk_sys, rst      : clock, synchronous active-high reset
//   clear             : synchronous flush (pointers and count to zero)
//   push/push_data/n  : append push_n low bytes of push_data, byte 0 first
//   pop/pop_n         : drop pop_n bytes from the head
//   peek_data         : the MAX_POP bytes at the head, head byte in bits 7:0
//   count/free        : occupied / free bytes
module dsi_byte_fifo #(
    parameter int DEPTH   = 16,
    parameter int MAX_POP = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int NW = $clog2(MAX_POP + 1)
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic [31:0]          push_data,
    input  logic [2:0]           push_n,
    input  logic                 pop,
    input  logic [NW-1:0]        pop_n,
    output logic [8*MAX_POP-1:0] peek_data,
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        free
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // Pointer + offset never reaches 2*DEPTH, so one subtraction wraps it;
    // this keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign free    = CW'(DEPTH) - count;
    // Guards keep the occupancy inside [0, DEPTH] even if a caller misbehaves.
    assign do_push = push && (free >= CW'(push_n));
    assign do_pop  = pop && (CW'(pop_n) <= count);

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(push_n)) mem[wrap(wr_ptr, k)] <= push_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap(wr_ptr, int'(push_n));
            if (do_pop)  rd_ptr <= wrap(rd_ptr, int'(pop_n));
            count <= count + (do_push ? CW'(push_n) : CW'(0)) - (do_pop ? CW'(pop_n) : CW'(0));
        end
    end

    always_comb begin
        peek_data = '0;
        for (int i = 0; i < MAX_POP; i++) peek_data[8*i +: 8] = mem[wrap(rd_ptr, i)];
    end

endmodule

// File: rtl/dsi_lane_striper.sv
// Splits a byte stream from the packet interface across N DSI HS lanes,
// byte i of each beat on lane i.
//   clk_sys, rst          : clock, synchronous active-high reset
//   iface_write_*         : packet words (data, strobe, valid), iface_last_word
//   iface_data_rqst       : ready for the packet interface
//   reg_lanes_number      : active lanes minus one, latched at packet start
//   lines_enable          : run/abort control
//   lanes_ready           : lane controllers accept one beat per cycle
//   lane_data/valid/last  : registered per-lane beat
//   packet_done           : one-cycle pulse after the final beat
//   data_underflow_error,
//   strb_error            : sticky error flags, cleared when leaving ERROR
module dsi_lane_striper
    import dsi_pkg::*;
#(
    parameter int LANES_MAX     = 4,
    parameter int BUF_WORDS     = 4,
    parameter int PREFILL_BYTES = 8,
    localparam int LN_W = (LANES_MAX > 1) ? $clog2(LANES_MAX) : 1
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    input  logic [31:0]            iface_write_data,
    input  logic [3:0]             iface_write_strb,
    input  logic                   iface_write_rqst,
    input  logic                   iface_last_word,
    output logic                   iface_data_rqst,
    input  logic [LN_W-1:0]        reg_lanes_number,
    input  logic                   lines_enable,
    input  logic                   lanes_ready,
    output logic [8*LANES_MAX-1:0] lane_data,
    output logic [LANES_MAX-1:0]   lane_valid,
    output logic [LANES_MAX-1:0]   lane_last,
    output logic                   packet_done,
    output logic                   data_underflow_error,
    output logic                   strb_error
);

    localparam int DEPTH = BUF_WORDS * 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NW    = $clog2(LANES_MAX + 1);

    dsi_state_t             state;
    dsi_word_t              wr_word;
    logic [NW-1:0]          n_lanes, n_req, m_bytes;
    logic                   last_acc;     // last word already in the buffer
    logic                   accept, stream_fire, final_seen;
    logic [2:0]             push_n;
    logic [CW-1:0]          count, free;
    logic [8*LANES_MAX-1:0] peek, beat_data;
    logic [LANES_MAX-1:0]   beat_valid, beat_last;
    int                     rem_after;

    assign wr_word = '{data: iface_write_data, strb: iface_write_strb, last: iface_last_word};
    assign push_n  = strb_bytes(wr_word.strb);

    // Ready is gated by lines_enable so nothing is taken in an abort cycle.
    assign iface_data_rqst = !rst && lines_enable && !last_acc && (free >= CW'(4))
                             && (state == ST_FILL || state == ST_STREAM);
    assign accept = iface_write_rqst && iface_data_rqst;

    // A beat goes out only with a full N bytes, or a short one once the
    // packet tail is already buffered.
    assign stream_fire = (state == ST_STREAM) && lines_enable && lanes_ready
                         && (int'(count) >= int'(n_lanes) || last_acc);

    always_comb begin
        int t;
        t     = int'(reg_lanes_number) + 1;
        n_req = NW'((t > LANES_MAX) ? LANES_MAX : t);
    end

    always_comb begin
        beat_data  = '0;
        beat_valid = '0;
        beat_last  = '0;
        m_bytes    = (int'(count) < int'(n_lanes)) ? NW'(count) : n_lanes;
        // A lane's byte is its final one when no later beat can reach that
        // lane: the packet tail is known (already in, or arriving now) and
        // fewer than i+1 bytes will remain after this beat.
        rem_after  = int'(count) - int'(m_bytes) + (accept ? int'(push_n) : 0);
        final_seen = last_acc || (accept && wr_word.last);
        for (int i = 0; i < LANES_MAX; i++) begin
            if (i < int'(m_bytes)) begin
                beat_valid[i]      = 1'b1;
                beat_data[8*i +: 8] = peek[8*i +: 8];
                beat_last[i]       = final_seen && (rem_after <= i);
            end
        end
    end

    dsi_byte_fifo #(
        .DEPTH   (DEPTH),
        .MAX_POP (LANES_MAX)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .clear     (!lines_enable),
        .push      (accept),
        .push_data (wr_word.data),
        .push_n    (push_n),
        .pop       (stream_fire),
        .pop_n     (m_bytes),
        .peek_data (peek),
        .count     (count),
        .free      (free)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state                <= ST_IDLE;
            n_lanes              <= NW'(1);
            last_acc             <= 1'b0;
            lane_data            <= '0;
            lane_valid           <= '0;
            lane_last            <= '0;
            packet_done          <= 1'b0;
            data_underflow_error <= 1'b0;
            strb_error           <= 1'b0;
        end else begin
            lane_data   <= '0;
            lane_valid  <= '0;
            lane_last   <= '0;
            packet_done <= 1'b0;
            if (accept && !strb_legal(wr_word.strb)) strb_error <= 1'b1;
            if (accept && wr_word.last) last_acc <= 1'b1;

            if (!lines_enable) begin
                state    <= ST_IDLE;
                last_acc <= 1'b0;
                if (state == ST_ERROR) begin
                    data_underflow_error <= 1'b0;
                    strb_error           <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_FILL;
                        n_lanes  <= n_req;
                        last_acc <= 1'b0;
                    end
                    ST_FILL: begin
                        if ((int'(count) >= PREFILL_BYTES || last_acc) && lanes_ready)
                            state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (stream_fire) begin
                            lane_data  <= beat_data;
                            lane_valid <= beat_valid;
                            lane_last  <= beat_last;
                            if (last_acc && int'(count) <= int'(n_lanes)) state <= ST_DONE;
                        end else begin
                            data_underflow_error <= 1'b1;
                            state                <= ST_ERROR;
                        end
                    end
                    ST_DONE: begin
                        packet_done <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    ST_ERROR: state <= ST_ERROR;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
